// File: rtl/inf_pkg.sv
// Shared definitions for the infix token buffer: token kinds, operator codes,
// error codes and the controller state encoding.
package inf_pkg;

    typedef enum logic [1:0] {
        KIND_NUM   = 2'd0,
        KIND_OPEN  = 2'd1,
        KIND_CLOSE = 2'd2,
        KIND_OP    = 2'd3
    } tok_kind_t;

    localparam int          TOK_OP_BIT = 32;
    localparam logic [11:0] OP_OPEN    = 12'h150;
    localparam logic [11:0] OP_CLOSE   = 12'h151;
    localparam logic [11:0] OP_ADD     = 12'h170;
    localparam logic [11:0] OP_SUB     = 12'h171;
    localparam logic [11:0] OP_MUL     = 12'h190;

    typedef enum logic [2:0] {
        ERR_NONE   = 3'd0,
        ERR_FULL   = 3'd1,
        ERR_PAREN  = 3'd2,
        ERR_EMPTY  = 3'd3,
        ERR_OVF    = 3'd4,
        ERR_DIV0   = 3'd5,
        ERR_SYNTAX = 3'd6,
        ERR_TMO    = 3'd7
    } err_t;

    typedef enum logic [1:0] {
        ST_EDIT  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Paren depth after pushing (undo=0) or removing (undo=1) a token of kind k.
    function automatic logic [7:0] depth_adj(input logic [7:0] d, input tok_kind_t k,
                                             input logic undo);
        logic [7:0] r;
        r = d;
        if (k == KIND_OPEN)  r = undo ? d - 8'd1 : d + 8'd1;
        if (k == KIND_CLOSE) r = undo ? d + 8'd1 : d - 8'd1;
        return r;
    endfunction

endpackage

// File: rtl/inf_tok_decode.sv
// Combinational token classifier (NUM / OPEN / CLOSE / OP); shared with the
// evaluator so both sides agree on token kinds.
module inf_tok_decode
    import inf_pkg::*;
#(
    parameter int DWIDTH = 36
) (
    input  logic [DWIDTH-1:0] tok,
    output logic [1:0]        kind
);

    logic unused_bits;
    assign unused_bits = ^{tok[DWIDTH-1:TOK_OP_BIT+1], tok[TOK_OP_BIT-1:12]};

    always_comb begin
        kind = KIND_NUM;
        if (tok[TOK_OP_BIT]) begin
            case (tok[11:0])
                OP_OPEN:  kind = KIND_OPEN;
                OP_CLOSE: kind = KIND_CLOSE;
                default:  kind = KIND_OP;
            endcase
        end
    end

endmodule

// File: rtl/inf_buffer_ctrl.sv
// Write-side owner of the infix token RAM: edits the buffer, tracks paren depth,
// and sequences one evaluator run per accepted EVAL.
module inf_buffer_ctrl
    import inf_pkg::*;
#(
    parameter int LEN       = 512,
    parameter int LOG_LEN   = 9,
    parameter int DWIDTH    = 36,
    parameter int START_CYC = 2,
    parameter int TIMEOUT   = 4095
) (
    input  logic               CLK_1MHz,
    input  logic               RST,
    input  logic               tok_valid,
    output logic               tok_ready,
    input  logic [DWIDTH-1:0]  tok_data,
    input  logic               bksp,
    input  logic               clr,
    input  logic               eval,
    output logic               en_inf_a,
    output logic               we_inf_a,
    output logic [LOG_LEN-1:0] addr_inf_a,
    output logic [DWIDTH-1:0]  dl_inf_a,
    output logic [LOG_LEN-1:0] top_addr_inf,
    output logic               inf_start,
    input  logic               finish,
    input  logic [31:0]        result,
    input  logic               overflow,
    input  logic               dv_by_zero,
    input  logic               syntax_error,
    output logic [31:0]        result_q,
    output logic [2:0]         err,
    output logic               busy,
    output logic               done
);

    localparam int CNT_MAX = (TIMEOUT > START_CYC) ? TIMEOUT : START_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [LOG_LEN-1:0] TOP_MAX = LOG_LEN'(LEN - 1);

    state_t             state, state_nx;
    logic [LOG_LEN-1:0] top;
    logic [7:0]         depth;
    err_t               err_q;
    logic [CNT_W-1:0]   cnt;
    logic               eval_pend;
    logic [1:0]         kind_mem [0:(2**LOG_LEN)-1];
    logic [1:0]         tok_kind_raw;
    tok_kind_t          tok_kind, rm_kind;

    logic edit, eval_req, full, tok_acc, tok_rej, tok_wr, tok_full;
    logic do_clr, do_bksp, do_eval, defer, eval_ok, start_last, wait_to;

    inf_tok_decode #(.DWIDTH(DWIDTH)) u_dec (
        .tok  (tok_data),
        .kind (tok_kind_raw)
    );

    assign tok_kind = tok_kind_t'(tok_kind_raw);
    assign rm_kind  = tok_kind_t'(kind_mem[top]);

    // Action arbitration inside EDIT: clr > bksp > eval > token.
    assign edit      = (state == ST_EDIT);
    assign eval_req  = eval | eval_pend;
    assign full      = (top == TOP_MAX);
    assign tok_ready = edit & ~full & ~clr & ~bksp & ~eval_req;
    assign tok_acc   = tok_valid & tok_ready;
    assign tok_rej   = (tok_kind == KIND_CLOSE) && (depth == 8'd0);
    assign tok_wr    = tok_acc & ~tok_rej;
    assign tok_full  = edit & tok_valid & full & ~clr & ~bksp & ~eval_req;
    assign do_clr    = edit & clr;
    assign do_bksp   = edit & ~clr & bksp & (top != '0);
    // An eval landing on a cycle with a write still in flight waits one cycle.
    assign do_eval   = edit & ~clr & ~bksp & eval_req & ~we_inf_a;
    assign defer     = edit & ~clr & ~bksp & eval_req & we_inf_a;
    assign eval_ok   = do_eval & (top != '0) & (depth == 8'd0);

    assign start_last = (cnt == CNT_W'(START_CYC - 1));
    assign wait_to    = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge CLK_1MHz) begin
        if (RST) state <= ST_EDIT;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_EDIT:  if (eval_ok)           state_nx = ST_START;
            ST_START: if (start_last)        state_nx = ST_WAIT;
            ST_WAIT:  if (finish || wait_to) state_nx = ST_DONE;
            ST_DONE:                         state_nx = ST_EDIT;
            default:                         state_nx = ST_EDIT;
        endcase
    end

    always_comb begin
        inf_start = (state == ST_START);
        busy      = ~edit;
        done      = (state == ST_DONE);
    end

    always_ff @(posedge CLK_1MHz) begin
        if (RST) begin
            top        <= '0;
            depth      <= 8'd0;
            err_q      <= ERR_NONE;
            result_q   <= 32'd0;
            cnt        <= '0;
            eval_pend  <= 1'b0;
            en_inf_a   <= 1'b0;
            we_inf_a   <= 1'b0;
            addr_inf_a <= '0;
            dl_inf_a   <= '0;
        end else begin
            en_inf_a  <= tok_wr;
            we_inf_a  <= tok_wr;
            eval_pend <= defer;
            if (tok_wr) begin
                addr_inf_a <= top + 1'b1;
                dl_inf_a   <= tok_data;
            end
            case (state)
                ST_EDIT: begin
                    cnt <= '0;
                    if (do_clr) begin
                        top   <= '0;
                        depth <= 8'd0;
                        err_q <= ERR_NONE;
                    end else if (do_bksp) begin
                        top   <= top - 1'b1;
                        depth <= depth_adj(depth, rm_kind, 1'b1);
                    end else if (do_eval) begin
                        if (top == '0)          err_q <= ERR_EMPTY;
                        else if (depth != 8'd0) err_q <= ERR_PAREN;
                        else                    err_q <= ERR_NONE;
                    end else if (tok_acc) begin
                        if (tok_rej) begin
                            err_q <= ERR_PAREN;
                        end else begin
                            top   <= top + 1'b1;
                            depth <= depth_adj(depth, tok_kind, 1'b0);
                            err_q <= ERR_NONE;
                        end
                    end else if (tok_full) begin
                        err_q <= ERR_FULL;
                    end
                end
                ST_START: cnt <= start_last ? '0 : cnt + 1'b1;
                ST_WAIT: begin
                    cnt <= cnt + 1'b1;
                    // finish beats the timeout when both land on the same cycle
                    if (finish) begin
                        result_q <= result;
                        err_q    <= overflow     ? ERR_OVF    :
                                    dv_by_zero   ? ERR_DIV0   :
                                    syntax_error ? ERR_SYNTAX : ERR_NONE;
                    end else if (wait_to) begin
                        err_q <= ERR_TMO;
                    end
                end
                default: ;
            endcase
        end
    end

    // Kind shadow of the RAM so backspace can undo the depth change.
    always_ff @(posedge CLK_1MHz) begin
        if (tok_wr) kind_mem[top + 1'b1] <= tok_kind_raw;
    end

    assign top_addr_inf = top;
    assign err          = err_q;

    a_wr_addr_nonzero: assert property (@(posedge CLK_1MHz) disable iff (RST)
        we_inf_a |-> (addr_inf_a != '0));
    a_top_in_range: assert property (@(posedge CLK_1MHz) disable iff (RST)
        top <= TOP_MAX);

endmodule

// File: tb/tb_inf_buffer_ctrl.sv
// Bench for inf_buffer_ctrl: queue-based behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_inf_buffer_ctrl;

    localparam int LEN = 16, LOG_LEN = 9, DWIDTH = 36, START_CYC = 2, TIMEOUT = 16;
    localparam logic [11:0] C_OPEN = 12'h150, C_CLOSE = 12'h151, C_ADD = 12'h170,
                            C_SUB = 12'h171, C_MUL = 12'h190;

    logic CLK_1MHz = 1'b0, RST = 1'b1;
    logic tok_valid = 1'b0, bksp = 1'b0, clr = 1'b0, eval = 1'b0;
    logic finish = 1'b0, overflow = 1'b0, dv_by_zero = 1'b0, syntax_error = 1'b0;
    logic [35:0] tok_data = '0;
    logic [31:0] result = '0;
    logic tok_ready, en_inf_a, we_inf_a, inf_start, busy, done;
    logic [8:0] addr_inf_a, top_addr_inf;
    logic [35:0] dl_inf_a;
    logic [31:0] result_q;
    logic [2:0] err;

    inf_buffer_ctrl #(.LEN(LEN), .LOG_LEN(LOG_LEN), .DWIDTH(DWIDTH),
                      .START_CYC(START_CYC), .TIMEOUT(TIMEOUT)) dut (
        .CLK_1MHz(CLK_1MHz), .RST(RST), .tok_valid(tok_valid), .tok_ready(tok_ready),
        .tok_data(tok_data), .bksp(bksp), .clr(clr), .eval(eval),
        .en_inf_a(en_inf_a), .we_inf_a(we_inf_a), .addr_inf_a(addr_inf_a),
        .dl_inf_a(dl_inf_a), .top_addr_inf(top_addr_inf), .inf_start(inf_start),
        .finish(finish), .result(result), .overflow(overflow), .dv_by_zero(dv_by_zero),
        .syntax_error(syntax_error), .result_q(result_q), .err(err), .busy(busy),
        .done(done)
    );

    always #5 CLK_1MHz = ~CLK_1MHz;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The buffer is a queue of tokens; depth is recounted from its contents.
    // m_run counts cycles since the evaluator was launched (0 = not running).
    logic [35:0] q[$];
    bit          m_valid = 0, m_done = 0, m_wr = 0, m_pend = 0;
    int          m_run = 0, m_wa = 0;
    logic [2:0]  m_err = 0;
    logic [31:0] m_res = 0;
    logic [35:0] m_wd = 0;

    function automatic bit is_code(input logic [35:0] t, input logic [11:0] c);
        return t[32] && (t[11:0] == c);
    endfunction

    function automatic int depth_of();
        int d = 0;
        foreach (q[i]) begin
            if (is_code(q[i], C_OPEN)) d++;
            else if (is_code(q[i], C_CLOSE)) d--;
        end
        return d;
    endfunction

    function automatic bit m_busy();
        return (m_run > 0) || m_done;
    endfunction

    function automatic bit m_ready();
        return !m_busy() && (q.size() != LEN - 1) && !clr && !bksp && !eval && !m_pend;
    endfunction

    always @(posedge CLK_1MHz) begin : model_step
        bit old_wr, old_pend;
        old_wr = m_wr; old_pend = m_pend;
        m_wr = 0; m_pend = 0;
        if (RST) begin
            q.delete(); m_run = 0; m_done = 0; m_err = 0; m_res = 0; m_valid = 1;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_run > 0) begin
            if (m_run <= START_CYC) m_run++;
            else if (finish) begin
                m_res = result;
                m_err = overflow ? 3'd4 : dv_by_zero ? 3'd5 : syntax_error ? 3'd6 : 3'd0;
                m_run = 0; m_done = 1;
            end else if (m_run - START_CYC == TIMEOUT) begin
                m_err = 3'd7; m_run = 0; m_done = 1;
            end else m_run++;
        end else if (clr) begin
            q.delete(); m_err = 0;
        end else if (bksp) begin
            if (q.size() > 0) void'(q.pop_back());
        end else if (eval || old_pend) begin
            if (old_wr) m_pend = 1;
            else if (q.size() == 0) m_err = 3'd3;
            else if (depth_of() != 0) m_err = 3'd2;
            else begin m_err = 3'd0; m_run = 1; end
        end else if (tok_valid) begin
            if (q.size() == LEN - 1) m_err = 3'd1;
            else if (is_code(tok_data, C_CLOSE) && depth_of() == 0) m_err = 3'd2;
            else begin
                q.push_back(tok_data);
                m_wr = 1; m_wa = q.size(); m_wd = tok_data; m_err = 3'd0;
            end
        end
    end

    // ---------------- per-cycle compare + event log ----------------
    int wl_a[$];
    logic [35:0] wl_d[$];
    int n_start = 0, n_done = 0;

    always @(negedge CLK_1MHz) begin
        #2;
        if (m_valid) begin
            chk("tok_ready", tok_ready, m_ready());
            chk("busy", busy, m_busy());
            chk("inf_start", inf_start, (m_run >= 1) && (m_run <= START_CYC));
            chk("done", done, m_done);
            chk("top_addr_inf", top_addr_inf, q.size());
            chk("err", err, m_err);
            chk("result_q", result_q, m_res);
            chk("we_inf_a", we_inf_a, m_wr);
            chk("en_inf_a", en_inf_a, m_wr);
            if (m_wr) begin
                chk("addr_inf_a", addr_inf_a, m_wa);
                chk("dl_inf_a", dl_inf_a, m_wd);
            end
        end
        if (we_inf_a === 1'b1) begin wl_a.push_back(int'(addr_inf_a)); wl_d.push_back(dl_inf_a); end
        if (inf_start === 1'b1) n_start++;
        if (done === 1'b1) n_done++;
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [35:0] op(input logic [11:0] c);
        logic [35:0] t;
        t = 36'h1_0000_0000;
        t[11:0] = c;
        return t;
    endfunction

    task automatic clear_in();
        RST = 0; tok_valid = 0; bksp = 0; clr = 0; eval = 0;
        finish = 0; overflow = 0; dv_by_zero = 0; syntax_error = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge CLK_1MHz); clear_in(); #1; end
    endtask

    task automatic push(input logic [35:0] t);
        @(negedge CLK_1MHz); clear_in(); tok_valid = 1; tok_data = t; #1;
    endtask

    task automatic cmd(input int c);
        @(negedge CLK_1MHz); clear_in();
        case (c)
            0: clr = 1;
            1: bksp = 1;
            default: eval = 1;
        endcase
        #1;
    endtask

    task automatic wait_phase();
        int k = 0;
        while (!(m_run > START_CYC) && k < 40) begin idle(1); k++; end
        if (k >= 40) begin n_chk++; n_err++; $display("FAIL wait_phase: never reached, expected within 40 cycles"); end
    endtask

    task automatic respond(input logic [31:0] r, input logic [2:0] fl, input bit give);
        int k = 0;
        wait_phase();
        if (give) begin
            @(negedge CLK_1MHz); clear_in();
            finish = 1; result = r; {overflow, dv_by_zero, syntax_error} = fl; #1;
        end
        while (m_busy() && k < 40) begin idle(1); k++; end
        if (k >= 40) begin n_chk++; n_err++; $display("FAIL run_end: still busy, expected idle within 40 cycles"); end
    endtask

    function automatic logic [35:0] rand_tok();
        logic [35:0] t;
        t = 36'($urandom);
        t[35:33] = 3'($urandom_range(0, 7));
        t[32] = 1'b0;
        case ($urandom_range(0, 9))
            0, 1, 2: ;
            3, 4: t = op(C_OPEN);
            5, 6: t = op(C_CLOSE);
            7: t = op(C_ADD);
            8: t = op($urandom_range(0, 1) ? C_SUB : C_MUL);
            default: t = op(12'h0AB);
        endcase
        return t;
    endfunction

    // ---------------- scenarios ----------------
    logic [35:0] expr[9];

    initial begin
        RST = 1;
        repeat (2) @(negedge CLK_1MHz);
        #1;
        chk("rst top", top_addr_inf, 0);
        chk("rst busy", busy, 0);
        chk("rst tok_ready", tok_ready, 1);
        chk("rst we", we_inf_a, 0);
        chk("rst addr", addr_inf_a, 0);
        chk("rst dl", dl_inf_a, 0);
        chk("rst inf_start", inf_start, 0);
        chk("rst err", err, 0);
        chk("rst result_q", result_q, 0);
        idle(1);

        // load 24.3 - ( 5 + 1 ) * 4 and run it
        expr = '{36'd243, op(C_SUB), op(C_OPEN), 36'd5, op(C_ADD), 36'd1, op(C_CLOSE),
                 op(C_MUL), 36'd4};
        wl_a.delete(); wl_d.delete(); n_start = 0; n_done = 0;
        foreach (expr[i]) push(expr[i]);
        cmd(2);
        respond(32'h0C0, 3'b000, 1);
        chk("load top", top_addr_inf, 9);
        chk("load nwrites", wl_a.size(), 9);
        for (int i = 0; i < 9 && i < wl_a.size(); i++) begin
            chk("load waddr", wl_a[i], i + 1);
            chk("load wdata", wl_d[i], expr[i]);
        end
        chk("load start_cycles", n_start, 2);
        chk("load result_q", result_q, 32'h0C0);
        chk("load err", err, 0);
        chk("load done_pulses", n_done, 1);

        // paren checks
        cmd(0); push(op(C_CLOSE)); idle(1);
        chk("paren close err", err, 2);
        chk("paren close top", top_addr_inf, 0);
        n_start = 0;
        push(op(C_OPEN)); push(36'd5); cmd(2); idle(3);
        chk("paren eval err", err, 2);
        chk("paren eval nostart", n_start, 0);

        // backspace restores depth
        cmd(0); push(op(C_OPEN)); push(36'd5); push(op(C_CLOSE)); cmd(1); cmd(1); idle(1);
        chk("bksp top", top_addr_inf, 1);
        push(op(C_CLOSE)); idle(1);
        chk("bksp close ok top", top_addr_inf, 2);
        chk("bksp close ok err", err, 0);
        push(op(C_CLOSE)); idle(1);
        chk("bksp depth0 err", err, 2);
        chk("bksp depth0 top", top_addr_inf, 2);
        cmd(0); push(op(C_CLOSE)); cmd(1); idle(1);
        chk("bksp empty top", top_addr_inf, 0);
        chk("bksp empty err", err, 2);

        // full buffer
        cmd(0);
        for (int i = 0; i < LEN; i++) push(36'(i + 100));
        idle(1);
        chk("full top", top_addr_inf, LEN - 1);
        chk("full ready", tok_ready, 0);
        chk("full err", err, 1);

        // evaluator error flag, then timeout on re-eval
        cmd(0); push(36'd7); idle(1); cmd(2);
        respond(32'd123, 3'b010, 1);
        chk("div0 err", err, 5);
        chk("div0 result_q", result_q, 123);
        n_done = 0;
        cmd(2);
        respond(32'd0, 3'b000, 0);
        chk("tmo err", err, 7);
        chk("tmo done_pulses", n_done, 1);
        chk("tmo top kept", top_addr_inf, 1);

        // lock while running, then reset in WAIT
        cmd(2); wait_phase();
        push(op(C_OPEN));
        chk("lock ready", tok_ready, 0);
        cmd(0); cmd(1); idle(1);
        chk("lock top", top_addr_inf, 1);
        chk("lock busy", busy, 1);
        @(negedge CLK_1MHz); clear_in(); RST = 1; #1;
        idle(1);
        chk("rst_mid inf_start", inf_start, 0);
        chk("rst_mid top", top_addr_inf, 0);
        chk("rst_mid busy", busy, 0);

        // randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            int r;
            @(negedge CLK_1MHz); clear_in();
            r = $urandom_range(0, 199);
            if (r == 0) RST = 1;
            else if (m_run > START_CYC && $urandom_range(0, 5) == 0) begin
                finish = 1; result = $urandom;
                overflow = ($urandom_range(0, 3) == 0);
                dv_by_zero = ($urandom_range(0, 3) == 0);
                syntax_error = ($urandom_range(0, 3) == 0);
            end else begin
                r = $urandom_range(0, 99);
                if (r < 2) clr = 1;
                else if (r < 10) bksp = 1;
                else if (r < 16) eval = 1;
                else if (r < 76) begin tok_valid = 1; tok_data = rand_tok(); end
            end
            #1;
        end
        idle(3);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected end before 500000");
        $fatal(1);
    end

endmodule

// File: doc/inf_buffer_ctrl.md
# inf_buffer_ctrl

Owns the write side of the 36-bit infix token RAM and sequences MB_INSTRUCTOR. It accepts tokens and edit commands from the entry logic, writes them into RAM port A, and maintains `top_addr_inf` and the parenthesis depth. On EVAL it pre-checks the expression, pulses `inf_start`, waits for `finish`, and latches the result and flags. Editing is locked while the evaluator runs.

## Interface
- `LEN` — default 512 — token RAM depth.
- `LOG_LEN` — default 9 — address width.
- `DWIDTH` — default 36 — token width.
- `START_CYC` — default 2 — `inf_start` high time, in cycles.
- `TIMEOUT` — default 4095 — maximum cycles to wait for `finish`.

Ports:
- `CLK_1MHz` in 1 — the single clock; all logic runs on the posedge.
- `RST` in 1 — reset, **synchronous, active-high**.
- `tok_valid` in 1 — token offer.
- `tok_ready` out 1 — token acceptance.
- `tok_data` in 36 — token.
- `bksp` in 1 — single-cycle command pulse.
- `clr` in 1 — single-cycle command pulse.
- `eval` in 1 — single-cycle command pulse.
- `en_inf_a` out 1 — RAM port A enable.
- `we_inf_a` out 1 — RAM port A write enable.
- `addr_inf_a` out 9 — RAM port A address.
- `dl_inf_a` out 36 — RAM port A write data.
- `top_addr_inf` out 9 — address of the last token; 0 = empty.
- `inf_start` out 1 — evaluator start.
- `finish` in 1 — evaluator done.
- `result` in 32 — evaluator result.
- `overflow` in 1 — evaluator flag.
- `dv_by_zero` in 1 — evaluator flag.
- `syntax_error` in 1 — evaluator flag.
- `result_q` out 32 — latched result.
- `err` out 3 — latched error code.
- `busy` out 1 — high outside EDIT.
- `done` out 1 — 1-cycle pulse per completed evaluation.

## Operation
Token decode:
- `tok_data[32]`=0 → NUM.
- `tok_data[32]`=1 → operator; code is `tok_data[11:0]`.
- Codes: 0x150 OPEN, 0x151 CLOSE, 0x170 ADD, 0x171 SUB, 0x190 MUL. Any other code → OP.

Storage:
- Tokens occupy addresses 1..`top_addr_inf`; address 0 is never written.
- An internal 2-bit kind array (NUM/OPEN/CLOSE/OP), indexed by address, supports backspace depth restore.
- `depth` is an 8-bit paren counter.

States: EDIT, START, WAIT, DONE.

EDIT handles one action per cycle, in priority `clr` > `bksp` > `eval` > token:
- **clr:** top←0, depth←0, err←0.
- **bksp:**
  - Ignored if top=0.
  - Otherwise top←top−1.
  - If the removed kind is OPEN, depth−1; if CLOSE, depth+1.
  - No RAM access.
- **token:** accepted when `tok_valid & tok_ready`.
  - CLOSE at depth 0 → rejected, err=2 (PAREN); nothing written.
  - Otherwise write at top+1, top←top+1, depth adjusts, err←0.
  - `tok_ready` = (state==EDIT) & (top≠LEN−1) & !`clr` & !`bksp` & !`eval`.
  - Token offered at top=LEN−1 → err=1 (FULL).
- **eval:**
  - top=0 → err=3 (EMPTY), stay in EDIT.
  - depth≠0 → err=2, stay in EDIT.
  - Otherwise err←0 → START.

START / WAIT / DONE:
- **START:** `inf_start`=1 for `START_CYC` cycles → WAIT.
- **WAIT:** count cycles.
  - `finish`=1 → latch `result_q`←`result`.
  - err ← 4 if `overflow`, else 5 if `dv_by_zero`, else 6 if `syntax_error`, else 0.
  - Then → DONE.
  - Count reaches `TIMEOUT` → err=7, → DONE.
- **DONE:** `done`=1 for one cycle → EDIT.
  - Buffer contents and top are preserved, so re-EVAL is allowed.

While `busy`: `tok_ready`=0, and `clr`/`bksp`/`eval` are ignored.

## Timing
- **Reset (first posedge with RST=1):**
  - State EDIT.
  - top, depth, err, `result_q`, counters = 0.
  - All strobes (`en_inf_a`, `we_inf_a`, `inf_start`, `done`) = 0.
  - `addr_inf_a`=0, `dl_inf_a`=0.
  - `busy`=0; `tok_ready`=1, since it is combinational and state is EDIT, top=0 and no command is asserted.
- **RST mid-operation:** returns to EDIT next edge and drops `inf_start` immediately. The RAM contents are stale but unreachable because top=0.
- **Write timing:**
  - The port A write is registered: a token accepted at edge N drives `en_inf_a`=`we_inf_a`=1, `addr_inf_a`=top+1 and `dl_inf_a`=token during cycle N→N+1.
  - The RAM captures it on the following negedge.
  - `top_addr_inf` updates at edge N, so it is visible at the same time as the write strobe.
  - Back-to-back tokens give one write per cycle.
- **`eval` → `inf_start`:** `inf_start` rises on the edge after `eval` and stays high exactly `START_CYC` cycles.
  - `eval` is sampled only if no write is pending, i.e. `we_inf_a`=0 in the current cycle. Otherwise it is deferred one cycle internally.
- **Completion:** `finish` sampled at edge M → `result_q`/`err` valid and `done`=1 from M through M+1; EDIT resumes at M+1.
- **Simultaneous events:**
  - `clr`+token: `clr` wins and the token is not accepted.
  - `finish` in the same cycle as TIMEOUT: `finish` wins.

## Structure
- Package `inf_pkg`:
  - token-kind enum;
  - operator code constants (0x150, 0x151, 0x170, 0x171, 0x190);
  - err codes 0–7;
  - FSM state encoding.
- One natural sub-module, `inf_tok_decode`: combinational classification of a token to its kind. It is reused by MB_INSTRUCTOR.

## Test plan
- **Load and run:** reset, push 24.3, −, (, 5, +, 1, ), *, 4 at one token/cycle, then eval.
  - `top_addr_inf`=9 and writes go to addresses 1..9 in order.
  - `inf_start` is high for 2 cycles.
  - Return `finish` with result 0x0C0 → `result_q`=0x0C0, err=0, a single `done` pulse.
- **Paren checks:** push CLOSE at depth 0 → err=2 and top unchanged. Push (, 5, then eval → err=2 and no `inf_start`.
- **Backspace:** push (, 5, ), then bksp×2 → top=1 and depth=1. Push ) → depth 0. bksp on empty → no change.
- **Full:** with LEN=8, push 8 tokens → top=7, `tok_ready`=0 after the 7th, err=1.
- **Evaluator error/timeout:** `finish` with `dv_by_zero`=1 → err=5. No `finish` within TIMEOUT=16 → err=7 and `done` is still pulsed.
- **Lock and reset:** during WAIT, drive `clr`/`bksp`/tokens → no effect and `tok_ready`=0. Assert RST in WAIT → `inf_start`=0, top=0, EDIT.
